// File: rtl/hdmi_line_sched.sv
// hdmi_line_sched: bank scheduler for a PPU-to-HDMI line buffer, clocked in the HDMI pixel domain.
//
// The PPU writer fills one bank per visible line. The HDMI reader replays each bank for SUB_Y
// output lines. The block tracks occupancy, flags overflow and underflow, and requests a PPU
// stall when the buffer is near full. After a fault it resynchronises the two frame cadences.
//
// Ports:
//   clk_h, rst_h      HDMI pixel clock; asynchronous active-high reset
//   wr_line_done      PPU finished the bank at wr_bank (already synchronised to clk_h)
//   wr_frame_start    PPU visible line 0 begins
//   rd_line_start     HDMI output line boundary
//   rd_frame_start    HDMI frame boundary (replaces rd_line_start in that cycle)
//   wr_bank, rd_bank  bank the PPU writes next / bank the HDMI reads
//   rd_valid          rd_bank holds valid data
//   out_line          PPU line index currently shown
//   level             completed, unretired banks, including the displayed one
//   stall_req         level is at NBUF-1 or higher while filling or running
//   overflow          1-cycle pulse
//   underflow         1-cycle pulse
//   locked            running with no fault since the last lock
//
// Optional feature macro HDMI_LINE_SCHED_STATS_EN adds ovf_cnt/unf_cnt. These are saturating
// fault counters that only rst_h clears.
module hdmi_line_sched #(
  parameter int unsigned NBUF           = 4,
  parameter int unsigned SUB_Y          = 2,
  parameter int unsigned ISCREEN_HEIGHT = 240,
  parameter int unsigned PREFILL        = 2
) (
  input  logic                    clk_h,
  input  logic                    rst_h,
  input  logic                    wr_line_done,
  input  logic                    wr_frame_start,
  input  logic                    rd_line_start,
  input  logic                    rd_frame_start,
  output logic [$clog2(NBUF)-1:0] wr_bank,
  output logic [$clog2(NBUF)-1:0] rd_bank,
  output logic                    rd_valid,
  output logic [8:0]              out_line,
  output logic [$clog2(NBUF):0]   level,
  output logic                    stall_req,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    locked
`ifdef HDMI_LINE_SCHED_STATS_EN
  ,
  output logic [15:0]             ovf_cnt,
  output logic [15:0]             unf_cnt
`endif
);

  localparam int unsigned BW = $clog2(NBUF);
  localparam int unsigned LW = BW + 1;
  localparam int unsigned SW = (SUB_Y > 1) ? $clog2(SUB_Y) : 1;

  typedef enum logic [1:0] {StIdle, StPrefill, StRun, StResync} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   wr_bank_q, wr_bank_d;
  logic [BW-1:0]   rd_bank_q, rd_bank_d;
  logic [LW-1:0]   level_q, level_d;
  logic [8:0]      out_line_q, out_line_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic            fault_q, fault_d;
  logic            valid_q, valid_d;
  logic            stall_q, stall_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            locked_q, locked_d;

  logic            wr_en, wr_ok, ret, ret_ok;

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    level_d    = level_q;
    out_line_d = out_line_q;
    sub_d      = sub_q;
    fault_d    = fault_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    ret        = 1'b0;

    wr_en = wr_line_done && ((state_q == StPrefill) || (state_q == StRun));

    if (state_q == StRun) begin
      if (rd_frame_start) begin
        ret   = 1'b1;
        sub_d = '0;
      end else if (rd_line_start) begin
        if (sub_q == SW'(SUB_Y - 1)) begin
          ret   = 1'b1;
          sub_d = '0;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
    end

    // Both fault checks use the pre-update level. A successful retire makes room for a write
    // in the same cycle.
    ret_ok = ret && (level_q >= LW'(2));
    unf_d  = ret && !ret_ok;
    ovf_d  = wr_en && (level_q == LW'(NBUF)) && !ret_ok;
    wr_ok  = wr_en && !ovf_d;

    level_d = level_q + LW'(wr_ok) - LW'(ret_ok);
    if (wr_ok) wr_bank_d = wr_bank_q + BW'(1);
    if (ret_ok) begin
      rd_bank_d = rd_bank_q + BW'(1);
      if (out_line_q < 9'(ISCREEN_HEIGHT - 1)) out_line_d = out_line_q + 9'd1;
    end
    if ((state_q == StRun) && rd_frame_start) out_line_d = '0;
    if (ovf_d || unf_d) fault_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (wr_frame_start) state_d = StPrefill;
      end
      StPrefill: begin
        if (rd_frame_start && (level_q >= LW'(PREFILL))) begin
          state_d    = StRun;
          out_line_d = '0;
          sub_d      = '0;
        end
      end
      StRun: begin
        if (rd_frame_start && fault_q) state_d = StResync;
      end
      StResync: begin
        if (wr_frame_start) state_d = StPrefill;
      end
      default: state_d = StIdle;
    endcase

    // Flush while in (or entering) resync. The reader restarts at the writer's bank, so the
    // two cadences line up again from the next PPU frame.
    if ((state_q == StResync) || (state_d == StResync)) begin
      level_d   = '0;
      rd_bank_d = wr_bank_d;
      fault_d   = 1'b0;
    end

    valid_d  = (state_d == StRun);
    locked_d = (state_d == StRun) && !fault_d;
    stall_d  = ((state_d == StPrefill) || (state_d == StRun)) && (level_d >= LW'(NBUF - 1));
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      state_q    <= StIdle;
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      level_q    <= '0;
      out_line_q <= '0;
      sub_q      <= '0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      level_q    <= level_d;
      out_line_q <= out_line_d;
      sub_q      <= sub_d;
      fault_q    <= fault_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      locked_q   <= locked_d;
    end
  end

  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign rd_valid  = valid_q;
  assign out_line  = out_line_q;
  assign level     = level_q;
  assign stall_req = stall_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign locked    = locked_q;

`ifdef HDMI_LINE_SCHED_STATS_EN
  logic [15:0] ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (ovf_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (unf_d && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`endif

endmodule
